// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared states, opcodes, ALU codes and mux selects for the multi-cycle controller
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_IMM   = 2'b01;
  localparam logic [1:0] SRC_B_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    return (op == OP_STORE) ? IMM_S : (op == OP_BRANCH) ? IMM_B : (op == OP_JAL) ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps funct3/funct7b5 to an ALU code and flags unsupported R/I-type encodings
module alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 is_rtype,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 legal
);
  logic [2:0] code;
  logic known;
  always_comb begin
    code = ALU_ADD;
    known = 1'b1;
    case (funct3)
      3'b000:  code = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b100:  code = ALU_XOR;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      3'b010:  code = ALU_SLT;
      default: known = 1'b0;
    endcase
  end
  // funct7b5 only selects sub; on any other R-type funct3 it marks an unsupported op
  assign legal = known && !(is_rtype && funct7b5 && funct3 != 3'b000);
  assign alu_control = ALUCTRL_W'(code);
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing fetch/decode/execute/memory/writeback with mem_ready stalls and a sticky trap
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic                 reg_write,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 illegal,
  output logic [3:0]           state_o
);
  state_t state, state_next;
  logic rdy, is_rtype, dec_legal, pc_w, ir_w, mem_w, reg_w;
  logic [ALUCTRL_W-1:0] dec_alu;
  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  // funct fields are only meaningful while decoding or executing an R/I op
  assign is_rtype = (state == DECODE) ? (op == OP_R) : (state == EXECR);
  alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (is_rtype),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= FETCH;
    else state <= state_next;
  always_comb begin
    state_next = state;
    pc_w = 1'b0;
    ir_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    adr_src = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RS2;
    alu_control = ALUCTRL_W'(ALU_ADD);
    illegal = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b = SRC_B_FOUR;
        result_src = RES_ALURESULT;
        ir_w = rdy;
        pc_w = rdy;
        state_next = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = (funct3 == 3'b010) ? MEMADR : TRAP;
          OP_R:              state_next = dec_legal ? EXECR : TRAP;
          OP_I:              state_next = dec_legal ? EXECI : TRAP;
          OP_BRANCH:         state_next = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
          OP_JAL:            state_next = JAL;
          default:           state_next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_next = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_next = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_w = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w = 1'b1;
        state_next = rdy ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a = SRC_A_RS1;
        alu_control = dec_alu;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_control = dec_alu;
        state_next = ALUWB;
      end
      ALUWB: begin
        reg_w = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_control = ALUCTRL_W'(ALU_SUB);
        pc_w = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);
        state_next = FETCH;
      end
      JAL: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_w = 1'b1;
        state_next = ALUWB;
      end
      TRAP:    illegal = 1'b1;
      default: state_next = FETCH;
    endcase
  end
  // enables are gated directly so nothing pulses while reset is held
  assign pc_write = pc_w && reset_n;
  assign ir_write = ir_w && reset_n;
  assign mem_write = mem_w && reset_n;
  assign reg_write = reg_w && reset_n;
  assign imm_src = imm_src_of(op);
  assign state_o = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven instruction vectors plus stall, trap and async-reset sequences
module tb_multicycle_control_unit;
  import riscv_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset_n, funct7b5, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;
  int total = 0;
  int passed = 0;
  typedef struct {
    string name;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    logic z;
    int cyc;
    int st3;
    int alu;
    int pcw;
    int rw;
    int imm;
  } vec_t;
  vec_t vecs[$];
  multicycle_control_unit dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .reg_write(reg_write), .alu_control(alu_control), .illegal(illegal), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask
  // runs one instruction from FETCH until the FSM returns to FETCH (12-cycle bound)
  task automatic run_vec(input vec_t v);
    int cyc, st3, alu3, pcw, rw, imm0;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z; mem_ready = 1'b1;
    cyc = 0; st3 = 0; alu3 = 0; pcw = 0; rw = 0; imm0 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cyc == 0) imm0 = int'(imm_src);
      if (cyc == 2) begin st3 = int'(state_o); alu3 = int'(alu_control); end
      pcw += int'(pc_write);
      rw += int'(reg_write);
      cyc++;
      @(posedge clk);
      #1;
      if (state_o == 4'(FETCH)) break;
    end
    check({v.name, " cycles"}, cyc, v.cyc);
    check({v.name, " state3"}, st3, v.st3);
    check({v.name, " alu3"}, alu3, v.alu);
    check({v.name, " pc_write count"}, pcw, v.pcw);
    check({v.name, " reg_write count"}, rw, v.rw);
    check({v.name, " imm_src"}, imm0, v.imm);
    if (v.st3 == int'(TRAP)) do_reset();
  endtask
  // one load/store with nlow mem_ready-low cycles injected in stall_st
  task automatic run_stall(input logic [6:0] o, input state_t stall_st, input int nlow,
                           output int cyc, output int rw, output int res_rw,
                           output int mw, output int mw_first, output int mw_last);
    int low;
    op = o; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    cyc = 0; rw = 0; res_rw = -1; mw = 0; mw_first = -1; mw_last = -1; low = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (state_o == 4'(stall_st) && low < nlow) begin mem_ready = 1'b0; low++; end
      else mem_ready = 1'b1;
      #1;
      if (reg_write) begin rw++; res_rw = int'(result_src); end
      if (mem_write) begin mw++; if (mw_first < 0) mw_first = cyc; mw_last = cyc; end
      cyc++;
      @(posedge clk);
      #1;
      if (state_o == 4'(FETCH)) break;
    end
    mem_ready = 1'b1;
  endtask
  initial begin
    int cyc, rw, res_rw, mw, mw_first, mw_last, bad;
    reset_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    vecs.push_back(vec_t'{"add",   OP_R, 3'b000, 1'b0, 1'b0, 4, int'(EXECR), 0, 1, 1, 0});
    vecs.push_back(vec_t'{"sub",   OP_R, 3'b000, 1'b1, 1'b0, 4, int'(EXECR), 1, 1, 1, 0});
    vecs.push_back(vec_t'{"xor",   OP_R, 3'b100, 1'b0, 1'b0, 4, int'(EXECR), 4, 1, 1, 0});
    vecs.push_back(vec_t'{"or",    OP_R, 3'b110, 1'b0, 1'b0, 4, int'(EXECR), 3, 1, 1, 0});
    vecs.push_back(vec_t'{"and",   OP_R, 3'b111, 1'b0, 1'b0, 4, int'(EXECR), 2, 1, 1, 0});
    vecs.push_back(vec_t'{"slt",   OP_R, 3'b010, 1'b0, 1'b0, 4, int'(EXECR), 5, 1, 1, 0});
    vecs.push_back(vec_t'{"r_f7x", OP_R, 3'b100, 1'b1, 1'b0, 12, int'(TRAP), 0, 1, 0, 0});
    vecs.push_back(vec_t'{"r_sll", OP_R, 3'b001, 1'b0, 1'b0, 12, int'(TRAP), 0, 1, 0, 0});
    vecs.push_back(vec_t'{"addi",  OP_I, 3'b000, 1'b1, 1'b0, 4, int'(EXECI), 0, 1, 1, 0});
    vecs.push_back(vec_t'{"ori",   OP_I, 3'b110, 1'b1, 1'b0, 4, int'(EXECI), 3, 1, 1, 0});
    vecs.push_back(vec_t'{"i_srl", OP_I, 3'b101, 1'b0, 1'b0, 12, int'(TRAP), 0, 1, 0, 0});
    vecs.push_back(vec_t'{"lw",    OP_LOAD, 3'b010, 1'b0, 1'b0, 5, int'(MEMADR), 0, 1, 1, 0});
    vecs.push_back(vec_t'{"lb",    OP_LOAD, 3'b000, 1'b0, 1'b0, 12, int'(TRAP), 0, 1, 0, 0});
    vecs.push_back(vec_t'{"sw",    OP_STORE, 3'b010, 1'b0, 1'b0, 4, int'(MEMADR), 0, 1, 0, 1});
    vecs.push_back(vec_t'{"beq_t", OP_BRANCH, 3'b000, 1'b0, 1'b1, 3, int'(BRANCH), 1, 2, 0, 2});
    vecs.push_back(vec_t'{"beq_n", OP_BRANCH, 3'b000, 1'b0, 1'b0, 3, int'(BRANCH), 1, 1, 0, 2});
    vecs.push_back(vec_t'{"bne_t", OP_BRANCH, 3'b001, 1'b0, 1'b0, 3, int'(BRANCH), 1, 2, 0, 2});
    vecs.push_back(vec_t'{"bne_n", OP_BRANCH, 3'b001, 1'b0, 1'b1, 3, int'(BRANCH), 1, 1, 0, 2});
    vecs.push_back(vec_t'{"blt",   OP_BRANCH, 3'b100, 1'b0, 1'b0, 12, int'(TRAP), 0, 1, 0, 2});
    vecs.push_back(vec_t'{"jal",   OP_JAL, 3'b000, 1'b0, 1'b0, 4, int'(JAL), 0, 2, 1, 3});
    vecs.push_back(vec_t'{"bad_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 12, int'(TRAP), 0, 1, 0, 0});
    #12;
    check("reset state", int'(state_o), 0);
    check("reset pc_write", int'(pc_write), 0);
    check("reset ir_write", int'(ir_write), 0);
    check("reset illegal", int'(illegal), 0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("fetch stall ir_write", int'(ir_write), 0);
    mem_ready = 1'b1;
    #1 check("fetch ready ir_write", int'(ir_write), 1);
    check("fetch ready pc_write", int'(pc_write), 1);
    foreach (vecs[i]) run_vec(vecs[i]);
    run_stall(OP_LOAD, MEMREAD, 2, cyc, rw, res_rw, mw, mw_first, mw_last);
    check("lw stall cycles", cyc, 7);
    check("lw stall reg_write count", rw, 1);
    check("lw stall result_src", res_rw, 1);
    check("lw stall mem_write count", mw, 0);
    run_stall(OP_STORE, MEMWRITE, 1, cyc, rw, res_rw, mw, mw_first, mw_last);
    check("sw stall cycles", cyc, 5);
    check("sw stall mem_write count", mw, 2);
    check("sw stall mem_write span", mw_last - mw_first, 1);
    check("sw stall reg_write count", rw, 0);
    check("sw back to fetch", int'(state_o), int'(FETCH));
    op = 7'b1111111; funct3 = 3'b000; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 10) op = OP_STORE;
      #1;
      if (state_o != 4'(TRAP) || !illegal || pc_write || ir_write || mem_write || reg_write) bad++;
    end
    check("trap 20 cycles violations", bad, 0);
    check("trap imm_src tracks op", int'(imm_src), int'(IMM_S));
    do_reset();
    #1 check("post-trap illegal", int'(illegal), 0);
    check("post-trap state", int'(state_o), 0);
    op = OP_STORE; funct3 = 3'b010; mem_ready = 1'b1;
    bad = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (state_o == 4'(MEMWRITE)) begin bad = 0; break; end
    end
    check("reached MEMWRITE", bad, 0);
    mem_ready = 1'b0;
    #1 check("memwrite before reset", int'(mem_write), 1);
    #1 reset_n = 1'b0;
    #1 check("async reset mem_write", int'(mem_write), 0);
    check("async reset state", int'(state_o), int'(FETCH));
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("after release ir_write low", int'(ir_write), 0);
    @(posedge clk);
    #1 check("fetch holds while not ready", int'(state_o), int'(FETCH));
    mem_ready = 1'b1;
    #1 check("after release ir_write high", int'(ir_write), 1);
    @(posedge clk);
    #1 check("fetch advances on ready", int'(state_o), int'(DECODE));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation controller for the multi-cycle core. Replaces the single-cycle control-word decoder.
- Registered Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Stalls on a memory-ready handshake, supports beq and bne, and traps stickily on unsupported encodings.
- Sits between the instruction register/flags and the datapath mux selects and write enables.

Parameters:
- ALUCTRL_W, 3: alu_control width. Codes below are zero-extended when wider; minimum 3.
- MEM_HANDSHAKE, 1: when 1, the memory states wait on mem_ready. When 0, mem_ready is internally tied to 1.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- op  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register enable
- result_src  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  ALU B select: 00=rs2, 01=Imm, 10=constant 4
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J; decoded from op in every state
- reg_write  out  1  register file write enable
- alu_control  out  ALUCTRL_W  ALU operation
- illegal  out  1  sticky trap flag
- state_o  out  4  current state encoding, for debug

Behaviour:

Reset and output rules:
- reset_n low forces state to FETCH asynchronously and clears illegal.
- While reset_n is low, pc_write, ir_write, mem_write and reg_write are forced to 0. All other outputs take their FETCH values.
- Every output not listed for a state is 0.

ALU codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.

States and actions:
- FETCH: adr_src=0, a=00, b=10, add, result_src=10. ir_write and pc_write equal mem_ready. Go to DECODE on mem_ready, otherwise hold.
- DECODE: a=01, b=01, add (precomputes the branch/jal target). Next state by op and legality:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - Anything else, or an illegal combination, → TRAP.
  - Legal combinations: R-type funct3 in {000, 100, 110, 111, 010}, with funct7b5 allowed only when funct3=000. I-type uses the same funct3 set with funct7b5 ignored. Loads and stores require funct3=010. Branches require funct3 in {000, 001}.
- MEMADR: a=10, b=01, add. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: adr_src=1, result_src=00. Go to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1. Go to FETCH.
- MEMWRITE: adr_src=1, result_src=00. mem_write held at 1 until and including the mem_ready cycle, then go to FETCH.
- EXECR: a=10, b=00. alu_control from funct3: 000 → add, or sub when funct7b5=1; 100 → xor; 110 → or; 111 → and; 010 → slt. Go to ALUWB.
- EXECI: a=10, b=01, same funct3 map but always add for 000. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Go to FETCH.
- BRANCH: a=10, b=00, sub, result_src=00. pc_write = (funct3==000 & zero) | (funct3==001 & ~zero). Go to FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_write=1. Go to ALUWB.
- TRAP: illegal=1 and all enables 0. Absorbing until reset.

Latency with mem_ready=1 throughout:
- R-type and I-type: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- branch: 3 cycles.
- jal: 4 cycles.
- Each low mem_ready cycle in FETCH, MEMREAD or MEMWRITE adds one cycle, with no duplicate enables.

Other boundary conditions:
- Inputs are sampled only in the states listed above. Changes to op elsewhere have no effect, except on imm_src, which always tracks op.
- Reset asserted mid-instruction aborts it immediately. No write enable pulses after reset_n falls.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state_t enum: FETCH=0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP;
  - opcode constants;
  - ALU code constants;
  - mux select constants.
- Sub-module alu_decoder: combinational; inputs funct3, funct7b5 and an is_rtype flag; outputs alu_control and a legal flag.

Test Plan:
- add (op=0110011, funct3=000, funct7b5=0), mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; alu_control=000 in EXECR; reg_write=1 only in cycle 4.
- lw with mem_ready low for 2 cycles in MEMREAD → 7-cycle instruction; reg_write pulses exactly once, in MEMWB, with result_src=01.
- sw with mem_ready low 1 cycle → mem_write=1 for 2 consecutive cycles, then FETCH.
- bne (funct3=001): zero=0 → pc_write=1 in BRANCH; zero=1 → pc_write=0; alu_control=001 in both cases.
- op=1111111 → TRAP after DECODE; illegal=1 with all enables 0 for 20 cycles; after reset_n pulse, illegal=0 and state_o=0.
- reset_n driven low mid-MEMWRITE (asynchronously, between clock edges) → mem_write drops to 0 immediately; after release, FETCH with ir_write following mem_ready.
